uart_tx_arbiter: RTL and testbench

Shares one UART transmitter byte port among N_REQ packet sources using packet-level round-robin arbitration. The grant is locked for a whole packet, up to and including the byte flagged last. An optional channel-ID header byte precedes each packet so the far-end receiver can demultiplex. A stall watchdog releases the grant when a granted source stops supplying bytes mid-packet.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its siblings.
package uart_pkg;

    localparam int BYTE_W   = 8;
    localparam int HDR_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Channel header: tag nibble, a zero spacer bit, then the 3-bit source id.
    function automatic logic [BYTE_W-1:0] hdr_byte(input logic [3:0]          tag,
                                                   input logic [HDR_ID_W-1:0] id);
        return {tag, 1'b0, id};
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request at or above ptr, with wrap.
module rr_picker
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        logic [ID_W-1:0] sel;
        gnt = '0;
        id  = '0;
        any = 1'b0;
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel = ID_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                id       = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmit byte port,
// with an optional channel header byte and a mid-packet stall watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          N_REQ   = 4,
    parameter bit          HDR_EN  = 1'b1,
    parameter logic [3:0]  HDR_TAG = 4'hA,
    parameter int          TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_valid,
    output logic [BYTE_W-1:0]       tx_data,
    input  logic                    tx_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    abort
);

    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_t        state, state_nxt;
    logic [N_REQ-1:0]  grant_nxt;
    logic [ID_W-1:0]   id_q, id_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_nxt;
    logic [CNT_W-1:0]  stall_cnt, cnt_nxt;

    logic [N_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]   pick_id;
    logic              pick_any;

    logic [BYTE_W-1:0] src_byte [N_REQ];
    logic              src_valid;
    logic              src_last;
    logic [ID_W-1:0]   next_id;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign src_byte[g] = req_data[BYTE_W*g +: BYTE_W];
    end

    assign src_valid = req_valid[id_q];
    assign src_last  = req_last[id_q];
    // The owner that just finished (or was aborted) drops to lowest priority.
    assign next_id   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
    assign busy      = (state != IDLE);

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .id  (pick_id),
        .any (pick_any)
    );

    // State, ownership, fairness pointer and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            id_q      <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            id_q      <= id_nxt;
            rr_ptr    <= rr_nxt;
            stall_cnt <= cnt_nxt;
        end
    end

    // Next-state logic and the combinational byte path to the transmitter.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        id_nxt    = id_q;
        rr_nxt    = rr_ptr;
        cnt_nxt   = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_gnt;
                    id_nxt    = pick_id;
                    state_nxt = HDR_EN ? HDR : DATA;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte(HDR_TAG, HDR_ID_W'(id_q));
                if (tx_ready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx_valid        = src_valid;
                tx_data         = src_byte[id_q];
                req_ready[id_q] = tx_ready;
                if (src_valid && tx_ready && src_last) begin
                    // Normal completion wins over a coincident watchdog expiry.
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    rr_nxt    = next_id;
                end else if (!src_valid) begin
                    if (stall_cnt == CNT_W'(TIMEOUT - 1)) begin
                        abort     = 1'b1;
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        rr_nxt    = next_id;
                    end else begin
                        cnt_nxt = stall_cnt + 1'b1;
                    end
                end
                // Source valid but transmitter busy: counter stays cleared.
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet table plus scoreboard on the main
// instance (N_REQ=4, header on, TIMEOUT=16) and a hand sequence on a
// second instance (N_REQ=2, header off).
module tb_uart_tx_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_last  = '0;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic [3:0]  grant;
    logic        busy;
    logic        abort;

    logic [1:0]  b_valid = '0;
    logic [15:0] b_data  = '0;
    logic [1:0]  b_last  = '0;
    logic [1:0]  b_ready;
    logic        b_txv;
    logic [7:0]  b_txd;
    logic        b_txr = 1'b1;
    logic [1:0]  b_grant;
    logic        b_busy;
    logic        b_abort;

    uart_tx_arbiter #(.N_REQ(4), .HDR_EN(1'b1), .HDR_TAG(4'hA), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .grant(grant), .busy(busy),
        .abort(abort)
    );

    uart_tx_arbiter #(.N_REQ(2), .HDR_EN(1'b0), .HDR_TAG(4'hA), .TIMEOUT(TO)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data),
        .req_last(b_last), .req_ready(b_ready), .tx_valid(b_txv),
        .tx_data(b_txd), .tx_ready(b_txr), .grant(b_grant), .busy(b_busy),
        .abort(b_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        int          len;
        bit          last;
        logic [31:0] bytes;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_hdr;
    } vec_t;

    vec_t        vt [17];
    logic [8:0]  src_q [4][$];
    logic [11:0] exp_q [$];

    int   n_err = 0;
    int   n_checks = 0;
    int   cyc = 0;
    int   abort_cnt = 0;
    int   abort_cyc = 0;
    int   last_xfer_cyc = 0;
    bit   bp_mode = 1'b0;
    int   bp_idx = 0;
    logic [3:0] bp_pat = 4'b1001;
    logic [3:0] hs;
    bit   held_v = 1'b0;
    logic [7:0] held_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    task automatic load(input int a, input int b);
        logic [7:0] d;
        for (int k = a; k <= b; k++) begin
            exp_q.push_back({vt[k].exp_grant, vt[k].exp_hdr});
            for (int j = 0; j < vt[k].len; j++) begin
                d = vt[k].bytes[8*j +: 8];
                src_q[vt[k].src].push_back({(vt[k].last && (j == vt[k].len - 1)), d});
                exp_q.push_back({vt[k].exp_grant, d});
            end
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 400) begin
            @(negedge clk); #1;
            t++;
        end
        n_checks++;
        if (t >= 400) begin
            n_err++;
            $display("FAIL %s: %0d bytes still expected after %0d cycles, required 0", name, exp_q.size(), t);
            flush();
        end
    endtask

    task automatic pulse_reset(input bit check_drop);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        if (check_drop) begin
            check("rst_grant", grant, 4'b0000);
            check("rst_tx_valid", tx_valid, 1'b0);
            check("rst_req_ready", req_ready, 4'b0000);
            check("rst_busy", busy, 1'b0);
        end
        flush();
        @(posedge clk); #3;
        rst = 1'b0;
    endtask

    // Source models: hold the head byte until it is accepted, then advance.
    initial begin : driver
        logic [8:0] e;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    e = src_q[i][0];
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = e[7:0];
                    req_last[i]         = e[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            tx_ready = bp_mode ? bp_pat[bp_idx] : 1'b1;
            bp_idx   = (bp_idx + 1) % 4;
        end
    end

    // Transmit-side monitor: scoreboard pop, hold stability, ready routing.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) check("hold_stable", {tx_valid, tx_data}, {1'b1, held_d});
            held_v = tx_valid & ~tx_ready;
            held_d = tx_data;
            if (req_ready != 4'b0000) check("req_ready_route", req_ready, grant & {4{tx_ready}});
            if (abort) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
            if (tx_valid && tx_ready) begin
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL tx_extra: got byte 0x%0h grant 0x%0h, required none", tx_data, grant);
                end else begin
                    check("tx_byte_grant", {grant, tx_data}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin : test
        int t;
        vt[0]  = '{2, 3, 1'b1, 32'h0033_2211, 4'b0100, 8'hA2};
        vt[1]  = '{3, 1, 1'b1, 32'h0000_003C, 4'b1000, 8'hA3};
        vt[2]  = '{0, 1, 1'b1, 32'h0000_000C, 4'b0001, 8'hA0};
        vt[3]  = '{0, 2, 1'b1, 32'h0000_0201, 4'b0001, 8'hA0};
        vt[4]  = '{1, 2, 1'b1, 32'h0000_1211, 4'b0010, 8'hA1};
        vt[5]  = '{2, 2, 1'b1, 32'h0000_2221, 4'b0100, 8'hA2};
        vt[6]  = '{3, 2, 1'b1, 32'h0000_3231, 4'b1000, 8'hA3};
        vt[7]  = '{0, 2, 1'b1, 32'h0000_0403, 4'b0001, 8'hA0};
        vt[8]  = '{1, 2, 1'b1, 32'h0000_1413, 4'b0010, 8'hA1};
        vt[9]  = '{2, 2, 1'b1, 32'h0000_2423, 4'b0100, 8'hA2};
        vt[10] = '{3, 2, 1'b1, 32'h0000_3433, 4'b1000, 8'hA3};
        vt[11] = '{1, 3, 1'b1, 32'h0073_7271, 4'b0010, 8'hA1};
        vt[12] = '{0, 1, 1'b0, 32'h0000_0055, 4'b0001, 8'hA0};
        vt[13] = '{1, 1, 1'b1, 32'h0000_0066, 4'b0010, 8'hA1};
        vt[14] = '{2, 4, 1'b1, 32'h8483_8281, 4'b0100, 8'hA2};
        vt[15] = '{0, 1, 1'b1, 32'h0000_0090, 4'b0001, 8'hA0};
        vt[16] = '{3, 1, 1'b1, 32'h0000_009F, 4'b1000, 8'hA3};

        // Reset state
        #3;
        check("reset_grant", grant, 4'b0000);
        check("reset_tx_valid", tx_valid, 1'b0);
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_req_ready", req_ready, 4'b0000);
        check("reset_busy", busy, 1'b0);
        check("reset_abort", abort, 1'b0);
        check("reset_b_grant", b_grant, 2'b00);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Single packet from src2, with one arbitration cycle first
        @(posedge clk); #2;
        load(0, 0);
        @(posedge clk); @(negedge clk); #1;
        check("arb_cycle_busy", busy, 1'b0);
        check("arb_cycle_grant", grant, 4'b0000);
        check("arb_cycle_tx_valid", tx_valid, 1'b0);
        drain("single_pkt");

        // Pointer now past src2: src3 beats src0
        @(posedge clk); #2;
        load(1, 2);
        drain("rr_ptr_after_src2");

        // Fairness from a fresh reset: 0,1,2,3,0,1,2,3
        pulse_reset(1'b0);
        @(posedge clk); #2;
        load(3, 10);
        drain("fairness");

        // Backpressure on src1 packet
        @(posedge clk); #2;
        bp_mode = 1'b1;
        bp_idx  = 0;
        load(11, 11);
        drain("backpressure");
        bp_mode = 1'b0;
        check("bp_no_abort", abort_cnt, 0);

        // Stall watchdog: src0 stops mid-packet, src1 pending
        @(posedge clk); #2;
        load(12, 13);
        t = 0;
        while (abort_cnt == 0 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        check("abort_seen", (t < 200), 1'b1);
        check("abort_delay", abort_cyc - last_xfer_cyc, TO);
        @(negedge clk); #1;
        check("abort_single_pulse", abort, 1'b0);
        check("abort_back_idle", busy, 1'b0);
        drain("after_abort_src1");
        check("abort_count", abort_cnt, 1);

        // Asynchronous reset in the middle of a src2 payload
        @(posedge clk); #2;
        load(14, 14);
        t = 0;
        while (exp_q.size() > 3 && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        check("mid_pkt_reached", (t < 100), 1'b1);
        @(posedge clk); #2;
        check("mid_pkt_busy", busy, 1'b1);
        pulse_reset(1'b1);
        @(posedge clk); #2;
        load(15, 16);
        drain("post_reset_src0_first");

        // No header, two sources: src0 first, then src1, then src0 again
        @(posedge clk); #1;
        b_valid = 2'b11;
        b_data  = {8'hC3, 8'h5A};
        b_last  = 2'b11;
        @(negedge clk);
        check("b_arb_grant", b_grant, 2'b00);
        check("b_arb_tx_valid", b_txv, 1'b0);
        @(negedge clk);
        check("b_first_grant", b_grant, 2'b01);
        check("b_first_byte", {b_txv, b_txd}, {1'b1, 8'h5A});
        check("b_first_ready", b_ready, 2'b01);
        @(posedge clk); #1;
        b_data[7:0] = 8'h5B;
        @(negedge clk);
        check("b_idle_between", {b_busy, b_grant}, 3'b000);
        @(negedge clk);
        check("b_second_grant", b_grant, 2'b10);
        check("b_second_byte", {b_txv, b_txd}, {1'b1, 8'hC3});
        @(posedge clk); #1;
        b_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b_third_grant", b_grant, 2'b01);
        check("b_third_byte", {b_txv, b_txd}, {1'b1, 8'h5B});
        @(posedge clk); #1;
        b_valid = 2'b00;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
